// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states,
// the latched request record and the store lane/byte-enable formatting.
package lsu_pkg;

  localparam int BE_W = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } lsu_req_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {F3_SB, F3_SH, F3_SW};
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

  // size is funct3[1:0]: 0 byte, 1 halfword, 2 word
  function automatic logic f3_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b01:   return ~off[0];
      2'b10:   return off == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return BE_W'(1) << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across every lane so the byte enables pick the bytes.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction: picks the addressed byte/halfword out of the read word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [15:0] lane;

  assign lane = 16'(rdata >> {off, 3'b000});

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   data = {{16{lane[15]}}, lane[15:0]};
      F3_LBU:  data = {24'b0, lane[7:0]};
      F3_LHU:  data = {16'b0, lane[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> REQ (until grant) -> WAIT (until rvalid),
// with alignment/funct3 checks, a saturating timeout and registered writeback.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd_addr,
  output logic        o_stall,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_wren,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state, state_nxt;
  lsu_req_t    lat;
  logic [7:0]  cnt;
  logic        done;
  logic        ok, accept, reject, progress, timeout;
  logic [31:0] ld_data;

  // done marks the retire cycle of the held instruction so it is not re-issued.
  assign ok       = f3_legal(i_we, i_funct3) && f3_aligned(i_funct3[1:0], i_addr[1:0]);
  assign accept   = (state == IDLE) && i_req && !done && ok;
  assign reject   = (state == IDLE) && i_req && !done && !ok;
  assign progress = ((state == REQ) && i_mem_gnt) || ((state == WAIT) && i_mem_rvalid);
  assign timeout  = (state != IDLE) && !progress && (cnt >= TO_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = REQ;
      REQ: begin
        if (i_mem_gnt)    state_nxt = WAIT;
        else if (timeout) state_nxt = IDLE;
      end
      WAIT: begin
        if (i_mem_rvalid) state_nxt = IDLE;
        else if (timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_stall     = !i_rst && (accept || (state != IDLE));
  assign o_mem_req   = (state == REQ);
  assign o_mem_we    = o_mem_req && lat.we;
  assign o_mem_addr  = o_mem_req ? {lat.addr[31:2], 2'b00} : 32'd0;
  assign o_mem_be    = !o_mem_req ? 4'b0000 :
                       lat.we ? store_be(lat.funct3[1:0], lat.addr[1:0]) : 4'b1111;
  assign o_mem_wdata = o_mem_we ? store_data(lat.funct3[1:0], lat.wdata) : 32'd0;

  lsu_load_align u_align (
    .rdata  (i_mem_rdata),
    .off    (lat.addr[1:0]),
    .funct3 (lat.funct3),
    .data   (ld_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lat          <= '0;
      cnt          <= '0;
      done         <= 1'b0;
      o_rd_addr    <= '0;
      o_rd_data    <= '0;
      o_rd_wren    <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
    end else begin
      done         <= 1'b0;
      o_rd_wren    <= 1'b0;
      o_misaligned <= reject;
      o_bus_err    <= timeout;
      if (accept) begin
        lat <= '{we: i_we, funct3: i_funct3, addr: i_addr, wdata: i_wdata, rd: i_rd_addr};
        cnt <= '0;
      end else if ((state != IDLE) && (cnt != 8'hFF)) begin
        cnt <= cnt + 8'd1;
      end
      if ((state == WAIT) && i_mem_rvalid) begin
        o_rd_data <= ld_data;
        o_rd_addr <= lat.rd;
        o_rd_wren <= !lat.we && (lat.rd != 5'd0);
        done      <= 1'b1;
      end
      if (timeout) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases with literal expectations plus random
// transactions; expectations come from a transaction-level model, checked every cycle.
module tb_load_store_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req = 1'b0, i_we = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic [4:0]  i_rd_addr = '0;
  logic        i_mem_gnt = 1'b0, i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_stall, o_rd_wren, o_misaligned, o_bus_err, o_mem_req, o_mem_we;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_rd_addr(i_rd_addr), .o_stall(o_stall),
    .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_rd_wren(o_rd_wren),
    .o_misaligned(o_misaligned), .o_bus_err(o_bus_err), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_be(o_mem_be), .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, issue_cyc = 0, berr_cyc = 0;
  int n_wren = 0, n_mis = 0, n_berr = 0, n_mreq = 0;
  bit chk_en = 1'b0, mis_pend = 1'b0;
  logic        e_stall, e_mreq, e_mwe, e_wren, e_mis, e_berr;
  logic [31:0] e_maddr, e_mwdata, e_rd_data;
  logic [3:0]  e_mbe;
  logic [4:0]  e_rd_addr;
  logic [31:0] cap_maddr = '0, cap_wdata = '0, cap_rd_data = '0;
  logic [3:0]  cap_be = '0;
  logic [4:0]  cap_rd_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("stall", 32'(o_stall), 32'(e_stall));
    chk("mem_req", 32'(o_mem_req), 32'(e_mreq));
    chk("rd_wren", 32'(o_rd_wren), 32'(e_wren));
    chk("misaligned", 32'(o_misaligned), 32'(e_mis));
    chk("bus_err", 32'(o_bus_err), 32'(e_berr));
    if (e_mreq) begin
      chk("mem_addr", o_mem_addr, e_maddr);
      chk("mem_we", 32'(o_mem_we), 32'(e_mwe));
      chk("mem_be", 32'(o_mem_be), 32'(e_mbe));
      if (e_mwe) chk("mem_wdata", o_mem_wdata, e_mwdata);
    end
    if (e_wren) begin
      chk("rd_addr", 32'(o_rd_addr), 32'(e_rd_addr));
      chk("rd_data", o_rd_data, e_rd_data);
    end
    if (o_mem_req) begin
      n_mreq++; cap_maddr = o_mem_addr; cap_be = o_mem_be; cap_wdata = o_mem_wdata;
    end
    if (o_rd_wren) begin n_wren++; cap_rd_data = o_rd_data; cap_rd_addr = o_rd_addr; end
    if (o_misaligned) n_mis++;
    if (o_bus_err) begin n_berr++; berr_cyc = cyc; end
  end

  // Start of a cycle: advance past the edge, default expectations, noise on rvalid.
  task automatic cyc_begin();
    @(posedge clk); #1;
    e_mis = mis_pend; mis_pend = 1'b0;
    e_stall = 0; e_mreq = 0; e_mwe = 0; e_wren = 0; e_berr = 0;
    e_maddr = '0; e_mwdata = '0; e_mbe = '0; e_rd_addr = '0; e_rd_data = '0;
    i_mem_gnt = 1'b0;
    i_mem_rvalid = 1'($urandom_range(0, 1));
    i_mem_rdata = $urandom;
  endtask

  task automatic idle_cyc();
    cyc_begin();
    i_req = 1'b0; i_we = 1'($urandom); i_funct3 = 3'($urandom);
    i_addr = $urandom; i_wdata = $urandom; i_rd_addr = 5'($urandom);
  endtask

  // One instruction: gnt arrives dg cycles after REQ entry, rvalid dr cycles after gnt.
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input int dg, input int dr, input logic [31:0] rdata);
    logic lg, al, granted, okay;
    int sz, nbytes;
    logic [3:0] eb;
    logic [31:0] ew, ed, lane;
    sz = int'(f3[1:0]);
    lg = we ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    al = (addr % (32'd1 << sz)) == 0;
    cyc_begin();
    issue_cyc = cyc;
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata; i_rd_addr = rd;
    if (!(lg && al)) begin
      mis_pend = 1'b1;
      return;
    end
    e_stall = 1'b1;
    nbytes = 1 << sz;
    eb = we ? 4'(((1 << nbytes) - 1) << addr[1:0]) : 4'hF;
    ew = (sz == 0) ? {4{wdata[7:0]}} : (sz == 1) ? {2{wdata[15:0]}} : wdata;
    lane = rdata >> (8 * addr[1:0]);
    case (f3)
      3'd0:    ed = 32'($signed(lane[7:0]));
      3'd1:    ed = 32'($signed(lane[15:0]));
      3'd4:    ed = lane & 32'hFF;
      3'd5:    ed = lane & 32'hFFFF;
      default: ed = rdata;
    endcase
    granted = 1'b0; okay = 1'b0;
    for (int k = 0; k < 256; k++) begin
      cyc_begin();
      e_stall = 1'b1;
      if (!granted) begin
        e_mreq = 1'b1; e_maddr = addr & ~32'd3; e_mwe = we; e_mbe = eb; e_mwdata = ew;
        if (k == dg) begin
          i_mem_gnt = 1'b1; i_mem_rvalid = 1'b0; granted = 1'b1;
        end else if (k >= T - 1) break;
      end else begin
        if (k == dg + 1 + dr) begin
          i_mem_rvalid = 1'b1; i_mem_rdata = rdata; okay = 1'b1;
          break;
        end
        i_mem_rvalid = 1'b0;
        if (k >= T - 1) break;
      end
    end
    cyc_begin();
    if (okay) begin
      e_wren = !we && (rd != 0); e_rd_addr = rd; e_rd_data = ed;
    end else begin
      e_berr = 1'b1;
    end
  endtask

  initial begin
    int w0, m0, b0, r0;
    logic we;
    logic [2:0] f3;
    logic [31:0] a;
    // Reset state, with a legal request presented during reset
    repeat (2) @(posedge clk);
    #1;
    i_req = 1'b1; i_funct3 = 3'd2; i_addr = 32'h100;
    #1;
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_mem_req", 32'(o_mem_req), 32'd0);
    chk("rst_rd_wren", 32'(o_rd_wren), 32'd0);
    chk("rst_rd_data", o_rd_data, 32'd0);
    chk("rst_misaligned", 32'(o_misaligned), 32'd0);
    chk("rst_bus_err", 32'(o_bus_err), 32'd0);
    idle_cyc();
    i_rst = 1'b0; chk_en = 1'b1;

    // LW 0x100, grant after 2 cycles
    w0 = n_wren;
    do_txn(1'b0, 3'd2, 32'h100, 32'h0, 5'd5, 2, 0, 32'hDEADBEEF);
    idle_cyc();
    chk("lw_mem_addr", cap_maddr, 32'h100);
    chk("lw_be", 32'(cap_be), 32'hF);
    chk("lw_wren_count", n_wren - w0, 1);
    chk("lw_rd_addr", 32'(cap_rd_addr), 32'd5);
    chk("lw_rd_data", cap_rd_data, 32'hDEADBEEF);

    do_txn(1'b0, 3'd0, 32'h103, 32'h0, 5'd7, 0, 0, 32'h80FFFF00);
    idle_cyc();
    chk("lb_rd_data", cap_rd_data, 32'hFFFFFF80);
    do_txn(1'b0, 3'd4, 32'h103, 32'h0, 5'd7, 1, 1, 32'h80FFFF00);
    idle_cyc();
    chk("lbu_rd_data", cap_rd_data, 32'h00000080);

    w0 = n_wren;
    do_txn(1'b1, 3'd1, 32'h102, 32'h0000ABCD, 5'd9, 0, 1, 32'h0);
    idle_cyc();
    chk("sh_be", 32'(cap_be), 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCDABCD);
    chk("sh_no_wren", n_wren - w0, 0);

    m0 = n_mis; r0 = n_mreq;
    do_txn(1'b0, 3'd2, 32'h101, 32'h0, 5'd3, 0, 0, 32'h0);
    idle_cyc();
    idle_cyc();
    chk("mis_count", n_mis - m0, 1);
    chk("mis_no_mem_req", n_mreq - r0, 0);

    b0 = n_berr; w0 = n_wren;
    do_txn(1'b0, 3'd2, 32'h200, 32'h0, 5'd4, 1000, 0, 32'h0);
    idle_cyc();
    chk("to_count", n_berr - b0, 1);
    chk("to_latency", berr_cyc - issue_cyc, 5);
    chk("to_no_wren", n_wren - w0, 0);

    // Reset in WAIT, then a late rvalid
    chk_en = 1'b0;
    cyc_begin();
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'd2; i_addr = 32'h300; i_rd_addr = 5'd3;
    cyc_begin(); i_mem_gnt = 1'b1; i_mem_rvalid = 1'b0;
    cyc_begin(); i_mem_rvalid = 1'b0;
    #3 i_rst = 1'b1;
    #1;
    chk("rstw_stall", 32'(o_stall), 32'd0);
    chk("rstw_mem_req", 32'(o_mem_req), 32'd0);
    chk("rstw_mem_addr", o_mem_addr, 32'd0);
    chk("rstw_rd_wren", 32'(o_rd_wren), 32'd0);
    chk("rstw_rd_data", o_rd_data, 32'd0);
    cyc_begin();
    i_rst = 1'b0; i_req = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h12345678;
    cyc_begin(); i_mem_rvalid = 1'b0;
    chk("late_rvalid_wren", 32'(o_rd_wren), 32'd0);
    chk("late_rvalid_stall", 32'(o_stall), 32'd0);
    cyc_begin();
    chk("late_rvalid_wren2", 32'(o_rd_wren), 32'd0);
    chk("late_rvalid_data", o_rd_data, 32'd0);
    chk_en = 1'b1;

    // Random instruction stream, mostly back-to-back
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
           (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 1) ? $urandom_range(0, 2)
                                                                      : $urandom_range(4, 5)));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (f3[1:0] == 2'd2) ? 2'd0 : (f3[1:0] == 2'd1) ? {a[1], 1'b0} : a[1:0];
      do_txn(we, f3, a, $urandom, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)),
             ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(0, 2)),
             ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(0, 2)), $urandom);
      repeat ($urandom_range(0, 3) == 0 ? 1 : 0) idle_cyc();
    end
    idle_cyc();
    idle_cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
